// File: rtl/ola_trigger_pkg.sv
// rtl/ola_trigger_pkg.sv - shared field encodings and FSM states for the trigger sequencer
package ola_trigger_pkg;

  // ctl_field encodings for configuration writes
  localparam logic [2:0] FIELD_VALUE      = 3'd0;
  localparam logic [2:0] FIELD_MASK       = 3'd1;
  localparam logic [2:0] FIELD_RISE_MASK  = 3'd2;
  localparam logic [2:0] FIELD_FALL_MASK  = 3'd3;
  localparam logic [2:0] FIELD_COUNT      = 3'd4;
  localparam logic [2:0] FIELD_LAST_STAGE = 3'd5;

  // sequencer state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRED = 2'd2
  } state_t;

endpackage

// File: rtl/ola_trigger_stage_match.sv
// rtl/ola_trigger_stage_match.sv - level/edge match of one sample against one stage (edges with OLA_TRIGGER_EDGES_EN)
module ola_trigger_stage_match #(
  parameter int sample_width = 8
) (
  input  logic [sample_width-1:0] i_sample,
  input  logic [sample_width-1:0] i_value,
  input  logic [sample_width-1:0] i_mask,
`ifdef OLA_TRIGGER_EDGES_EN
  input  logic [sample_width-1:0] i_prev,
  input  logic [sample_width-1:0] i_rise_mask,
  input  logic [sample_width-1:0] i_fall_mask,
`endif
  output logic                    o_match
);

  logic w_level_hit;
  logic w_edge_hit;

  assign w_level_hit = (((i_sample ^ i_value) & i_mask) == '0);

`ifdef OLA_TRIGGER_EDGES_EN
  logic [sample_width-1:0] w_rising;
  logic [sample_width-1:0] w_falling;
  logic                    w_edge_used;

  assign w_rising    = ~i_prev & i_sample;
  assign w_falling   = i_prev & ~i_sample;
  assign w_edge_used = |(i_rise_mask | i_fall_mask);
  // an all-zero edge mask pair means the stage is level-only
  assign w_edge_hit  = !w_edge_used || (|((w_rising & i_rise_mask) | (w_falling & i_fall_mask)));
`else
  assign w_edge_hit  = 1'b1;
`endif

  assign o_match = w_level_hit && w_edge_hit;

endmodule

// File: rtl/ola_trigger_sequencer.sv
// rtl/ola_trigger_sequencer.sv - multi-stage logic-analyser trigger sequencer (edge terms under OLA_TRIGGER_EDGES_EN)
module ola_trigger_sequencer
  import ola_trigger_pkg::*;
#(
  parameter int sample_width    = 8,
  parameter int stage_count     = 4,
  parameter int stage_sel_width = 2,
  parameter int count_width     = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       ctl_enable,
  input  logic                       ctl_write,
  input  logic [stage_sel_width-1:0] ctl_stage,
  input  logic [2:0]                 ctl_field,
  input  logic [count_width-1:0]     ctl_data,
  input  logic                       in_valid,
  input  logic [sample_width-1:0]    in_sample,
  output logic                       out_valid,
  output logic [sample_width-1:0]    out_sample,
  output logic                       out_trigger,
  output logic [stage_sel_width-1:0] out_stage,
  output logic                       out_armed
);

  // per-stage configuration
  logic [sample_width-1:0]    r_value [stage_count];
  logic [sample_width-1:0]    r_mask  [stage_count];
  logic [count_width-1:0]     r_count [stage_count];
  logic [stage_sel_width-1:0] r_last_stage;
`ifdef OLA_TRIGGER_EDGES_EN
  logic [sample_width-1:0]    r_rise_mask [stage_count];
  logic [sample_width-1:0]    r_fall_mask [stage_count];
  logic [sample_width-1:0]    r_prev;
`endif

  // sequencer state
  state_t                     r_state;
  logic [stage_sel_width-1:0] r_stage;
  logic [count_width-1:0]     r_occ;
  logic                       r_trigger;
  logic                       r_armed;
  logic                       r_valid;
  logic [sample_width-1:0]    r_sample;

  logic                       w_cfg_wr;
  logic                       w_stage_ok;
  logic [stage_sel_width-1:0] w_last_clamped;
  logic                       w_match;

  // configuration is frozen once the sequencer leaves IDLE
  assign w_cfg_wr   = ctl_write && (r_state == ST_IDLE);
  assign w_stage_ok = (32'(ctl_stage) < stage_count);

  // out-of-range last_stage is clamped against the full write data, not a truncated copy
  always_comb begin
    w_last_clamped = ctl_data[stage_sel_width-1:0];
    if (ctl_data >= count_width'(stage_count)) begin
      w_last_clamped = stage_sel_width'(stage_count - 1);
    end
  end

  // configuration register file, written only while idle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < stage_count; k++) begin
        r_value[k] <= '0;
        r_mask[k]  <= '0;
        r_count[k] <= '0;
`ifdef OLA_TRIGGER_EDGES_EN
        r_rise_mask[k] <= '0;
        r_fall_mask[k] <= '0;
`endif
      end
      r_last_stage <= '0;
    end else if (w_cfg_wr) begin
      case (ctl_field)
        FIELD_VALUE:      if (w_stage_ok) r_value[ctl_stage] <= ctl_data[sample_width-1:0];
        FIELD_MASK:       if (w_stage_ok) r_mask[ctl_stage]  <= ctl_data[sample_width-1:0];
`ifdef OLA_TRIGGER_EDGES_EN
        FIELD_RISE_MASK:  if (w_stage_ok) r_rise_mask[ctl_stage] <= ctl_data[sample_width-1:0];
        FIELD_FALL_MASK:  if (w_stage_ok) r_fall_mask[ctl_stage] <= ctl_data[sample_width-1:0];
`endif
        FIELD_COUNT:      if (w_stage_ok) r_count[ctl_stage] <= ctl_data;
        FIELD_LAST_STAGE: r_last_stage <= w_last_clamped;
        default: ;
      endcase
    end
  end

`ifdef OLA_TRIGGER_EDGES_EN
  // previous valid sample, the reference for edge detection
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_prev <= '0;
    end else if (in_valid) begin
      r_prev <= in_sample;
    end
  end
`endif

  ola_trigger_stage_match #(
    .sample_width (sample_width)
  ) u_stage_match (
    .i_sample    (in_sample),
    .i_value     (r_value[r_stage]),
    .i_mask      (r_mask[r_stage]),
`ifdef OLA_TRIGGER_EDGES_EN
    .i_prev      (r_prev),
    .i_rise_mask (r_rise_mask[r_stage]),
    .i_fall_mask (r_fall_mask[r_stage]),
`endif
    .o_match     (w_match)
  );

  // sequencer FSM: arm, count matches per stage, fire once on the last stage
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_stage   <= '0;
      r_occ     <= '0;
      r_trigger <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_trigger <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_stage <= '0;
          r_occ   <= '0;
          if (ctl_enable) begin
            r_state <= ST_ARMED;
            r_armed <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (!ctl_enable) begin
            // disable beats a coincident final match
            r_state <= ST_IDLE;
            r_armed <= 1'b0;
          end else if (in_valid && w_match) begin
            if (r_occ == r_count[r_stage]) begin
              r_occ <= '0;
              if (r_stage == r_last_stage) begin
                r_state   <= ST_FIRED;
                r_armed   <= 1'b0;
                r_trigger <= 1'b1;
              end else begin
                r_stage <= r_stage + 1'b1;
              end
            end else begin
              r_occ <= r_occ + 1'b1;
            end
          end
        end
        ST_FIRED: begin
          if (!ctl_enable) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_armed <= 1'b0;
        end
      endcase
    end
  end

  // one-cycle sample pipeline alongside the trigger
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid  <= 1'b0;
      r_sample <= '0;
    end else begin
      r_valid  <= in_valid;
      r_sample <= in_sample;
    end
  end

  assign out_valid   = r_valid;
  assign out_sample  = r_sample;
  assign out_trigger = r_trigger;
  assign out_stage   = r_stage;
  assign out_armed   = r_armed;

endmodule

// File: doc/ola_trigger_sequencer.md
OLA_TRIGGER_SEQUENCER -- requirements
Module: ola_trigger_sequencer

Interface
REQ-001 Parameter sample_width, default 8, sample bus width.
REQ-002 Parameter stage_count, default 4, number of trigger stages.
REQ-003 Parameter stage_sel_width, default 2, width of the stage index; 2**stage_sel_width SHALL be >= stage_count.
REQ-004 Parameter count_width, default 16, width of the per-stage occurrence count; SHALL be >= sample_width.
REQ-005 clock  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 ctl_enable  in  1  high = armed or running; low = idle and configurable.
REQ-008 ctl_write  in  1  one-cycle configuration write strobe.
REQ-009 ctl_stage  in  stage_sel_width  stage addressed by the write.
REQ-010 ctl_field  in  3  field select: 0 value, 1 mask, 2 rise_mask, 3 fall_mask, 4 count, 5 last_stage.
REQ-011 ctl_data  in  count_width  write data; value and mask fields use the low sample_width bits.
REQ-012 in_valid  in  1  sample strobe.
REQ-013 in_sample  in  sample_width  sample.
REQ-014 out_valid  out  1  registered in_valid.
REQ-015 out_sample  out  sample_width  registered in_sample.
REQ-016 out_trigger  out  1  one-cycle pulse aligned with the sample that completes the final stage.
REQ-017 out_stage  out  stage_sel_width  current stage index.
REQ-018 out_armed  out  1  high in state ARMED.

Function
REQ-019 out_valid, out_sample, out_trigger and out_stage SHALL lag their inputs by exactly one clock.
REQ-020 Edges SHALL be computed against the previous valid sample: rising = ~prev & cur, falling = prev & ~cur; prev SHALL update only on in_valid.
REQ-021 Stage k SHALL match on a valid sample when ((in_sample ^ value[k]) & mask[k]) == 0 and, if rise_mask[k] | fall_mask[k] is nonzero, (rising & rise_mask[k]) | (falling & fall_mask[k]) is nonzero.
REQ-022 FSM states: IDLE, ARMED, FIRED.
REQ-023 IDLE -> ARMED on the first cycle with ctl_enable high; this SHALL clear the stage index and occurrence counter.
REQ-024 In ARMED, a matching sample SHALL increment the occurrence counter; when the counter equals count[stage], the stage SHALL advance and the counter SHALL clear.
REQ-025 When the stage equal to last_stage completes: state -> FIRED and out_trigger pulses for one cycle.
REQ-026 Count 0 SHALL mean one match; non-matching samples SHALL NOT reset the counter.
REQ-027 FIRED SHALL persist until ctl_enable goes low; no further triggers.
REQ-028 ctl_enable low in any state -> IDLE next cycle; if it coincides with a final match, IDLE wins and no trigger is issued.
REQ-029 Writes SHALL take effect only in IDLE; writes in ARMED or FIRED are ignored.
REQ-030 last_stage >= stage_count SHALL be clamped to stage_count-1.

Reset
REQ-031 On reset assertion: state IDLE, stage 0, counter 0, prev 0, all outputs 0.
REQ-032 Reset: value 0, mask 0, rise_mask 0, fall_mask 0, count 0, last_stage 0; a bare enable then triggers on the first valid sample.
REQ-033 Reset mid-run SHALL abort the sequence with no trigger pulse.

Configuration
REQ-034 Macro OLA_TRIGGER_EDGES_EN: defined = edge terms, edge registers and edge masks present.
REQ-035 Without OLA_TRIGGER_EDGES_EN, the edge term SHALL be treated as true, writes to fields 2/3 are ignored and their storage is removed.

Structure
REQ-036 Package ola_trigger_pkg SHALL hold the ctl_field encodings and the FSM state encoding.
REQ-037 Sub-module ola_trigger_stage_match SHALL implement the REQ-021 match for one stage; instantiated once, fed the current stage's configuration.

Verification
REQ-038 Stage0 value 8'hA5, mask 8'hFF, last 0; enable; samples 00,A5 -> out_trigger one cycle after A5, out_stage 0.
REQ-039 Stages 0/1 = 8'h01/8'h02 full mask, last 1; samples 02,01,03,02 -> trigger on the second 02 only.
REQ-040 Stage0 count 2, value 8'h10; samples 10,00,10,10 -> trigger on the third 10.
REQ-041 Stage0 rise_mask 8'h01, mask 0; samples 01,01,00,01 -> trigger on sample 1 (prev 0) only once, FIRED holds.
REQ-042 ctl_enable dropped on the same cycle as the completing sample -> no trigger, out_armed 0 next cycle.
REQ-043 reset asserted while at stage 1 of 3 -> outputs 0 immediately, re-enable restarts at stage 0.
